// File: rtl/elixirchip_es1_spu_pkg.sv
// ---------------------------------------------------------------------------
// elixirchip_es1_spu_pkg : shared types for multi-beat SPU readers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package elixirchip_es1_spu_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } spu_rd_state_t;

endpackage

`default_nettype wire

// File: rtl/elixirchip_es1_spu_op_regrd.sv
// ---------------------------------------------------------------------------
// elixirchip_es1_spu_op_regrd : snapshots a register bank, drains it serially
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module elixirchip_es1_spu_op_regrd
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int    NUM_REGS   = 4,
  parameter int    DATA_BITS  = 8,
  parameter type   data_t     = logic [DATA_BITS-1:0],
  parameter data_t CLEAR_DATA = '0,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false",
  localparam int   INDEX_BITS = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cke,
  input  logic [NUM_REGS*DATA_BITS-1:0] s_data,
  input  logic                          s_snap,
  input  logic                          s_clear,
  output logic                          s_busy,
  output logic [DATA_BITS-1:0]          m_data,
  output logic [INDEX_BITS-1:0]         m_index,
  output logic                          m_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_overrun
);

  localparam logic [INDEX_BITS-1:0] c_last_index = INDEX_BITS'(NUM_REGS - 1);

  function automatic data_t get_word(input logic [NUM_REGS*DATA_BITS-1:0] bank,
                                     input logic [INDEX_BITS-1:0]         idx);
    return bank[idx*DATA_BITS +: DATA_BITS];
  endfunction

  spu_rd_state_t               r_state;
  spu_rd_state_t               w_state_next;
  logic [NUM_REGS*DATA_BITS-1:0] r_bank;
  logic [INDEX_BITS-1:0]       r_index;
  data_t                       r_data;
  logic                        r_overrun;

  logic w_accept;
  logic w_final;
  logic w_load;
  logic w_drop;

  assign w_accept = (r_state == SEND) && m_ready && cke;
  assign w_final  = w_accept && (r_index == c_last_index);
  // A snap on the final accepted beat restarts immediately instead of overrunning.
  assign w_load   = !s_clear && s_snap && ((r_state == IDLE) || w_final);
  assign w_drop   = !s_clear && s_snap && (r_state == SEND) && !w_final;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (cke) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (s_clear) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (s_snap) w_state_next = SEND;
        SEND:    if (w_final) w_state_next = s_snap ? SEND : IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    m_valid = (r_state == SEND);
    s_busy  = (r_state == SEND);
    m_last  = (r_state == SEND) && (r_index == c_last_index);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_index   <= '0;
      r_data    <= CLEAR_DATA;
      r_overrun <= 1'b0;
    end else if (cke) begin
      if (s_clear) begin
        r_index   <= '0;
        r_data    <= CLEAR_DATA;
        r_overrun <= 1'b0;
      end else begin
        if (w_load) begin
          r_index <= '0;
          r_data  <= get_word(s_data, '0);
        end else if (w_accept && (r_index != c_last_index)) begin
          r_index <= INDEX_BITS'(r_index + 1'b1);
          r_data  <= get_word(r_bank, INDEX_BITS'(r_index + 1'b1));
        end else if (w_final) begin
          r_index <= '0;
        end
        if (w_drop) begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  // Snapshot storage needs no reset; it is only read after a load.
  always_ff @(posedge clk) begin
    if (cke && w_load) begin
      r_bank <= s_data;
    end
  end

  assign m_data    = r_data;
  assign m_index   = r_index;
  assign m_overrun = r_overrun;

  generate
    if (SIMULATION == "true") begin : g_sim_checks
      a_num_regs: assert property (@(posedge clk) NUM_REGS >= 2)
        else $error("%s: NUM_REGS must be at least 2", DEVICE);
      a_hold: assert property (@(posedge clk) disable iff (reset)
                               (m_valid && !m_ready && !s_clear) |=> ($stable(m_data) && $stable(m_index)))
        else $error("%s: stream word changed while stalled (debug=%s)", DEVICE, DEBUG);
    end
  endgenerate

endmodule

`default_nettype wire

// File: doc/elixirchip_es1_spu_op_regrd.md
Name: elixirchip_es1_spu_op_regrd

Overview:
Register-bank reader for the ES1 SPU. It captures a parallel bank of NUM_REGS operand registers in one cycle on a snapshot strobe. It then emits the captured words one per beat on a valid/ready stream, each tagged with its index and a last flag. It is the read-out counterpart of the SPU register op: those ops load words in parallel, and this block drains them serially toward a debug or host port.

Parameters:
NUM_REGS, 4, number of words captured per snapshot (must be >= 2)
DATA_BITS, 8, width of one word
data_t, logic [DATA_BITS-1:0], word type
INDEX_BITS, $clog2(NUM_REGS), width of m_index (derived; do not override)
CLEAR_DATA, '0, value m_data takes on reset/clear
DEVICE, "RTL", device name, passed through
SIMULATION, "false", enables simulation assertions
DEBUG, "false", debug attributes

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
cke  in  1  clock enable; when 0, all state and outputs hold and m_ready is ignored
s_data  in  NUM_REGS*DATA_BITS  register bank; word i at [i*DATA_BITS +: DATA_BITS]
s_snap  in  1  snapshot request
s_clear  in  1  synchronous abort; flushes any transfer in progress
s_busy  out  1  1 while a snapshot is being drained
m_data  out  DATA_BITS  current word
m_index  out  INDEX_BITS  index of current word
m_last  out  1  high on the word with index NUM_REGS-1
m_valid  out  1  stream valid
m_ready  in  1  stream ready
m_overrun  out  1  sticky; set when s_snap is dropped

Behaviour:
- Reset values (asynchronous, applied immediately on reset=1):
  - state=IDLE
  - m_valid=0, s_busy=0, m_last=0, m_overrun=0
  - m_index=0
  - m_data=CLEAR_DATA
  - snapshot buffer contents are don't-care.
- All actions below require cke=1. With cke=0, nothing changes.
- States:
  - IDLE: m_valid=0, s_busy=0.
  - SEND: m_valid=1, s_busy=1.
- IDLE -> SEND, on s_snap=1 at edge N:
  - all NUM_REGS words of s_data are latched into the buffer at edge N.
  - from edge N, m_valid=1, m_index=0, m_data=word0.
  - latency from snap to the first valid word is 1 cycle.
- Beat acceptance in SEND: a beat is accepted when m_valid & m_ready & cke.
  - On acceptance with m_index<NUM_REGS-1: m_index increments and m_data shows the next word in the following cycle.
  - Without acceptance, m_data, m_index and m_last are held stable (AXI-Stream rule).
- m_last = (m_index==NUM_REGS-1) & m_valid.
- Final beat: when the beat with m_last=1 is accepted, the next state is IDLE and m_valid=0.
  - A simultaneous s_snap in that same cycle is treated as an IDLE snap. The next state is SEND with new data and index 0, giving back-to-back snapshots with no bubble.
- s_snap in SEND, other than the final-accept cycle: the snap is ignored, the buffer is unchanged, and m_overrun is set to 1.
- s_clear=1: forces state=IDLE, m_valid=0, m_index=0, m_data=CLEAR_DATA, m_overrun=0 in the next cycle.
  - s_clear has priority over s_snap and over acceptance.
- Reset asserted mid-transfer: immediately returns all outputs to their reset values; the transfer is lost.
- m_valid never depends combinationally on m_ready.
- No combinational path from s_* to m_*.
- Simulation only (SIMULATION="true"): assert that NUM_REGS>=2, and that m_data and m_index are stable while m_valid & !m_ready.

Decomposition:
- Shared package elixirchip_es1_spu_pkg: the state enum type (IDLE, SEND) for reuse by other multi-beat SPU readers.
- Helper function for slicing word i from a packed bank.
- INDEX_BITS is computed locally.
- No sub-module is needed: the buffer, index counter and FSM fit in one module.
- No extra pipeline latency is added. If it is ever needed, it belongs in a wrapper, not in this block.

Test Plan:
- Basic drain: NUM_REGS=4, DATA_BITS=8, s_data=0x44_33_22_11, s_snap pulse, m_ready=1 -> m_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles; m_index 0..3; m_last only on 0x44; s_busy high for those 4 cycles; no overrun.
- Backpressure: m_ready toggling 1,0,0,1,... -> each word held stable while m_ready=0; no word skipped or duplicated; a change to s_data during the drain has no effect on the output.
- Back-to-back snaps: second s_snap with s_data=0xDD_CC_BB_AA coincides with acceptance of 0x44 -> next cycle m_data=0xAA, m_index=0; m_valid stays high; m_overrun=0.
- Overrun: s_snap asserted while m_index=1 -> remaining words still come from the first snapshot; m_overrun=1 and stays 1 after return to IDLE; a following s_clear -> m_overrun=0.
- cke gating and clear: cke=0 for 3 cycles mid-drain with m_ready=1 -> outputs frozen, no beat counted. Then s_clear=1 together with s_snap=1 -> next cycle m_valid=0, m_data=CLEAR_DATA, IDLE.
- Async reset: assert reset between clock edges at m_index=2 -> m_valid, s_busy and m_index go to 0 without waiting for a clock edge. After release, a new s_snap drains correctly from index 0.
